// File: rtl/bsg_manycore_pkt_decode.sv
// Receive-side decoder for manycore remote-store packets: destination/opcode filter feeding a 2-entry FIFO.
// Optional dropped-packet counter enabled by `define BSG_MANYCORE_PKT_DECODE_STATS_EN.
module bsg_manycore_pkt_decode #(
  parameter int x_cord_width_p = 4,
  parameter int y_cord_width_p = 5,
  parameter int data_width_p   = 32,
  parameter int addr_width_p   = 20,
  localparam int packet_width_lp = addr_width_p + 2 + data_width_p/8 + data_width_p
                                   + 2*(x_cord_width_p + y_cord_width_p)
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          v_i,
  input  logic [packet_width_lp-1:0]    data_i,
  output logic                          ready_o,
  input  logic [x_cord_width_p-1:0]     my_x_i,
  input  logic [y_cord_width_p-1:0]     my_y_i,
  output logic                          v_o,
  input  logic                          yumi_i,
  output logic                          cfg_o,
  output logic [addr_width_p-1:0]       addr_o,
  output logic [data_width_p-1:0]       data_o,
  output logic [data_width_p/8-1:0]     mask_o,
  output logic [x_cord_width_p-1:0]     src_x_o,
  output logic [y_cord_width_p-1:0]     src_y_o,
  output logic [15:0]                   drop_cnt_o,
  output logic                          err_o
);

  localparam int mask_width_lp = data_width_p/8;
  localparam int dest_y_lsb_lp = x_cord_width_p;
  localparam int src_x_lsb_lp  = x_cord_width_p + y_cord_width_p;
  localparam int src_y_lsb_lp  = 2*x_cord_width_p + y_cord_width_p;
  localparam int data_lsb_lp   = 2*(x_cord_width_p + y_cord_width_p);
  localparam int mask_lsb_lp   = data_lsb_lp + data_width_p;
  localparam int op_lsb_lp     = mask_lsb_lp + mask_width_lp;
  localparam int addr_lsb_lp   = op_lsb_lp + 2;

  typedef struct packed {
    logic                      cfg;
    logic [addr_width_p-1:0]   addr;
    logic [data_width_p-1:0]   data;
    logic [mask_width_lp-1:0]  mask;
    logic [x_cord_width_p-1:0] src_x;
    logic [y_cord_width_p-1:0] src_y;
  } entry_s;

  logic [x_cord_width_p-1:0] dest_x;
  logic [y_cord_width_p-1:0] dest_y;
  logic [1:0]                op;
  logic                      dest_match, op_ok, accept, enq, deq, op_err;
  entry_s                    in_entry, head;

  entry_s     mem [2];
  logic       wr_ptr, rd_ptr;
  logic [1:0] count;
  logic       err_r;

  assign dest_x = data_i[0 +: x_cord_width_p];
  assign dest_y = data_i[dest_y_lsb_lp +: y_cord_width_p];
  assign op     = data_i[op_lsb_lp +: 2];

  assign in_entry.cfg   = (op == 2'b10);
  assign in_entry.addr  = data_i[addr_lsb_lp +: addr_width_p];
  assign in_entry.data  = data_i[data_lsb_lp +: data_width_p];
  assign in_entry.mask  = data_i[mask_lsb_lp +: mask_width_lp];
  assign in_entry.src_x = data_i[src_x_lsb_lp +: x_cord_width_p];
  assign in_entry.src_y = data_i[src_y_lsb_lp +: y_cord_width_p];

  assign dest_match = (dest_x == my_x_i) && (dest_y == my_y_i);
  assign op_ok      = (op == 2'b01) || (op == 2'b10);

  // ready_o depends only on the registered count, so a same-cycle yumi cannot free a full slot
  assign ready_o = (count != 2'd2);
  assign v_o     = (count != 2'd0);
  assign accept  = v_i & ready_o;
  assign enq     = accept & dest_match & op_ok;
  assign deq     = yumi_i & v_o;
  // a destination mismatch masks an opcode fault, so only local packets can raise err_o
  assign op_err  = accept & dest_match & ~op_ok;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
      err_r  <= 1'b0;
    end else begin
      if (enq) begin
        mem[wr_ptr] <= in_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (deq) rd_ptr <= ~rd_ptr;
      case ({enq, deq})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (op_err) err_r <= 1'b1;
    end
  end

  assign head    = mem[rd_ptr];
  assign cfg_o   = head.cfg;
  assign addr_o  = head.addr;
  assign data_o  = head.data;
  assign mask_o  = head.mask;
  assign src_x_o = head.src_x;
  assign src_y_o = head.src_y;
  assign err_o   = err_r;

`ifdef BSG_MANYCORE_PKT_DECODE_STATS_EN
  logic        drop;
  logic [15:0] drop_cnt_r;

  assign drop = accept & ~(dest_match & op_ok);

  always_ff @(posedge clk_i) begin
    if (reset_i)                          drop_cnt_r <= '0;
    else if (drop && (drop_cnt_r != '1))  drop_cnt_r <= drop_cnt_r + 16'd1;
  end

  assign drop_cnt_o = drop_cnt_r;
`else
  assign drop_cnt_o = '0;
`endif

`ifndef SYNTHESIS
  yumi_requires_valid: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o);
`endif

endmodule

// File: tb/tb_bsg_manycore_pkt_decode.sv
// Scoreboard bench for bsg_manycore_pkt_decode: directed scenarios followed by randomized traffic.
module tb_bsg_manycore_pkt_decode;

  localparam int PW = 76;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b1;
  logic          v_i = 1'b0;
  logic [PW-1:0] data_i = '0;
  logic          ready_o;
  logic [3:0]    my_x_i = 4'd3;
  logic [4:0]    my_y_i = 5'd5;
  logic          v_o;
  logic          yumi_i = 1'b0;
  logic          cfg_o;
  logic [19:0]   addr_o;
  logic [31:0]   data_o;
  logic [3:0]    mask_o;
  logic [3:0]    src_x_o;
  logic [4:0]    src_y_o;
  logic [15:0]   drop_cnt_o;
  logic          err_o;

  bsg_manycore_pkt_decode #(
    .x_cord_width_p(4),
    .y_cord_width_p(5),
    .data_width_p(32),
    .addr_width_p(20)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .data_i(data_i), .ready_o(ready_o),
    .my_x_i(my_x_i), .my_y_i(my_y_i), .v_o(v_o), .yumi_i(yumi_i), .cfg_o(cfg_o),
    .addr_o(addr_o), .data_o(data_o), .mask_o(mask_o), .src_x_o(src_x_o),
    .src_y_o(src_y_o), .drop_cnt_o(drop_cnt_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit        cfg;
    bit [19:0] addr;
    bit [31:0] data;
    bit [3:0]  mask;
    bit [3:0]  sx;
    bit [4:0]  sy;
  } exp_t;

  exp_t        q[$];
  bit          model_full = 1'b0;
  bit          err_m = 1'b0;
  int unsigned drops_m = 0;
  int          yumi_mode = 0;   // 0 never, 1 always, 2 random
  bit          yumi_once = 1'b0;
  bit          mon_en = 1'b0;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_drop();
`ifdef BSG_MANYCORE_PKT_DECODE_STATS_EN
    return (drops_m > 32'd65535) ? 16'hFFFF : 16'(drops_m);
`else
    return 16'h0;
`endif
  endfunction

  // Monitor: compares the DUT against the model every cycle and consumes the head.
  initial begin
    wait (mon_en);
    forever begin
      @(negedge clk_i);
      chk("v_o", v_o, q.size() != 0);
      chk("ready_o", ready_o, q.size() < 2);
      chk("err_o", err_o, err_m);
      chk("drop_cnt_o", drop_cnt_o, exp_drop());
      if (v_o && q.size() > 0) begin
        chk("cfg_o", cfg_o, q[0].cfg);
        chk("addr_o", addr_o, q[0].addr);
        chk("data_o", data_o, q[0].data);
        chk("mask_o", mask_o, q[0].mask);
        chk("src_x_o", src_x_o, q[0].sx);
        chk("src_y_o", src_y_o, q[0].sy);
      end
      model_full = (q.size() == 2);
      yumi_i = 1'b0;
      if (v_o && q.size() > 0 &&
          (yumi_mode == 1 || (yumi_mode == 2 && $urandom_range(1, 0) == 1) || yumi_once)) begin
        yumi_i = 1'b1;
        yumi_once = 1'b0;
        void'(q.pop_front());
      end
    end
  end

  // Offers a packet until the model says it is accepted; the model then classifies it.
  task automatic send(input bit [19:0] addr, input bit [1:0] op, input bit [3:0] mask,
                      input bit [31:0] data, input bit [3:0] sx, input bit [4:0] sy,
                      input bit [3:0] dx, input bit [4:0] dy);
    int unsigned n = 0;
    bit done = 1'b0;
    exp_t e;
    while (!done) begin
      @(negedge clk_i); #1;
      v_i = 1'b1;
      data_i = {addr, op, mask, data, sy, sx, dy, dx};
      if (!model_full) begin
        done = 1'b1;
        if (dx != my_x_i || dy != my_y_i) drops_m++;
        else if (op == 2'b00 || op == 2'b11) begin
          drops_m++;
          err_m = 1'b1;
        end else begin
          e.cfg = (op == 2'b10); e.addr = addr; e.data = data; e.mask = mask;
          e.sx = sx; e.sy = sy;
          q.push_back(e);
        end
      end else if (++n > 100) begin
        chk("send_timeout", 1, 0);
        done = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_i); #1;
      v_i = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i); #1;
    v_i = 1'b0;
    reset_i = 1'b1;
    q.delete();
    err_m = 1'b0;
    drops_m = 0;
    @(negedge clk_i); #1;
    chk("rst_addr_o", addr_o, 0);
    chk("rst_data_o", data_o, 0);
    chk("rst_mask_o", mask_o, 0);
    chk("rst_src_o", {src_x_o, src_y_o}, 0);
    reset_i = 1'b0;
  endtask

  task automatic send_rand();
    int unsigned kind = $urandom_range(9, 0);
    bit [1:0] op = $urandom_range(1, 0) ? 2'b01 : 2'b10;
    bit [3:0] dx = my_x_i;
    bit [4:0] dy = my_y_i;
    if (kind >= 6 && kind <= 7) dx = my_x_i + 4'(1 + $urandom_range(14, 0));
    if (kind >= 8) op = $urandom_range(1, 0) ? 2'b00 : 2'b11;
    if (kind == 9 && $urandom_range(1, 0) == 1) dy = my_y_i + 5'(1 + $urandom_range(30, 0));
    send(20'($urandom), op, 4'($urandom), $urandom, 4'($urandom), 5'($urandom), dx, dy);
  endtask

  initial begin
    repeat (2) @(posedge clk_i);
    mon_en = 1'b1;
    @(negedge clk_i); #1;
    reset_i = 1'b0;
    chk("init_addr_o", addr_o, 0);

    // Test 1: single memory store, then consumed
    send(20'h00ABC, 2'b01, 4'hF, 32'hDEADBEEF, 4'd1, 5'd2, 4'd3, 5'd5);
    yumi_mode = 1;
    idle(3);

    // Test 2: fill, back-pressure, drain across the pointer wrap
    yumi_mode = 0;
    send(20'h00001, 2'b10, 4'h1, 32'h11111111, 4'd2, 5'd3, 4'd3, 5'd5);
    send(20'h00002, 2'b01, 4'h3, 32'h22222222, 4'd4, 5'd6, 4'd3, 5'd5);
    fork
      send(20'h00003, 2'b10, 4'h7, 32'h33333333, 4'd5, 5'd7, 4'd3, 5'd5);
      begin repeat (3) @(negedge clk_i); yumi_once = 1'b1; end
    join
    yumi_mode = 1;
    idle(4);

    // Test 3: destination mismatch, both faults, then illegal opcode
    send(20'h00010, 2'b01, 4'hF, 32'hCAFEF00D, 4'd0, 5'd0, 4'd4, 5'd5);
    send(20'h00011, 2'b11, 4'hF, 32'h0BADF00D, 4'd0, 5'd0, 4'd3, 5'd6);
    idle(2);
    send(20'h00012, 2'b11, 4'hF, 32'h0BADBEEF, 4'd0, 5'd0, 4'd3, 5'd5);
    idle(2);

    // Test 5: dequeue and enqueue in the same cycle at count 1
    yumi_mode = 0;
    send(20'h00020, 2'b01, 4'hA, 32'hA5A5A5A5, 4'd6, 5'd9, 4'd3, 5'd5);
    yumi_once = 1'b1;
    send(20'h00021, 2'b10, 4'h5, 32'h5A5A5A5A, 4'd7, 5'd10, 4'd3, 5'd5);
    idle(2);
    yumi_mode = 1;
    idle(2);

    // Test 6: reset with two entries queued, then 1-cycle latency
    yumi_mode = 0;
    send(20'h00030, 2'b01, 4'h1, 32'h01020304, 4'd1, 5'd1, 4'd3, 5'd5);
    send(20'h00031, 2'b01, 4'h2, 32'h05060708, 4'd2, 5'd2, 4'd3, 5'd5);
    idle(1);
    do_reset();
    send(20'h00040, 2'b10, 4'hC, 32'h87654321, 4'd8, 5'd17, 4'd3, 5'd5);
    idle(1);
    yumi_mode = 1;
    idle(2);

    // Randomized traffic with random consumption and one mid-stream reset
    yumi_mode = 2;
    my_x_i = 4'($urandom);
    my_y_i = 5'($urandom);
    for (int i = 0; i < 400; i++) begin
      send_rand();
      if ($urandom_range(3, 0) == 0) idle($urandom_range(2, 1));
      if (i == 200) do_reset();
    end
    yumi_mode = 1;
    idle(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bsg_manycore_pkt_decode.md
Name: bsg_manycore_pkt_decode

Overview:
- Receive-side endpoint for manycore remote-store packets. It is the decoder counterpart of the existing packet encoder.
- Accepts packed packets from the network with a valid/ready handshake. Checks the destination against the local tile coordinates and checks the opcode.
- Buffers legal packets in a 2-entry FIFO and presents decoded fields to the local memory/config port with a valid/yumi handshake.
- Sits between the mesh router's local output port and the tile's data memory.

Parameters:
- x_cord_width_p, 4, width of X coordinate fields.
- y_cord_width_p, 5, width of Y coordinate fields.
- data_width_p, 32, store data width; mask width is data_width_p/8.
- addr_width_p, 20, word-address width carried in the packet.
- packet_width_lp (local), addr_width_p+2+data_width_p/8+data_width_p+2*(x_cord_width_p+y_cord_width_p), 76 with defaults.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- v_i  in  1  incoming packet valid.
- data_i  in  packet_width_lp  packed packet.
- ready_o  out  1  decoder can accept a packet this cycle.
- my_x_i  in  x_cord_width_p  local tile X.
- my_y_i  in  y_cord_width_p  local tile Y.
- v_o  out  1  decoded request valid.
- yumi_i  in  1  consumer takes the head request (legal only when v_o=1).
- cfg_o  out  1  1 = config store (op 2'b10), 0 = memory store (op 2'b01).
- addr_o  out  addr_width_p  word address.
- data_o  out  data_width_p  store data.
- mask_o  out  data_width_p/8  byte mask.
- src_x_o  out  x_cord_width_p  sender X.
- src_y_o  out  y_cord_width_p  sender Y.
- drop_cnt_o  out  16  dropped-packet count (only with the optional feature; otherwise tied 0).
- err_o  out  1  sticky: an illegal opcode was seen.

Behaviour:
- Packet layout, MSB to LSB (defaults shown):
  - addr [75:56]
  - op [55:54]
  - mask [53:50]
  - data [49:18]
  - src_y [17:13]
  - src_x [12:9]
  - dest_y [8:4]
  - dest_x [3:0]
- Accept condition: v_i & ready_o. ready_o = ~full, driven from registered state only, with no combinational path from yumi_i. When full, no enqueue occurs even if yumi_i=1 in the same cycle.
- Classification of an accepted packet:
  - Legal: dest_x==my_x_i, dest_y==my_y_i, and op is 2'b01 or 2'b10. Enqueued.
  - Dest mismatch: dropped, not enqueued, not an error.
  - Op 2'b00 or 2'b11 with dest matching: dropped and sets err_o.
  - Both faults present: treated as a mismatch drop only; err_o is not set.
- FIFO: 2 entries, circular read/write pointers plus count. Stores only decoded fields (cfg, addr, data, mask, src_x, src_y).
- Latency: a packet accepted at edge N drives v_o=1 from cycle N+1. There is no bypass.
- Outputs reflect the head entry whenever v_o=1.
- Dequeue occurs on yumi_i. yumi_i while v_o=0 is ignored (the implementation asserts on this in simulation only).
- Simultaneous enqueue and dequeue with count 1: count stays 1, the head advances, and v_o stays 1.
- Dequeue of the last entry with no enqueue: v_o=0 in the next cycle.
- Pointer wrap: each pointer is 1 bit and toggles from 1 back to 0.
- Reset (also applies mid-operation):
  - FIFO emptied, so v_o=0.
  - ready_o=1 in the first cycle after reset.
  - err_o=0, drop_cnt_o=0.
  - In-flight entries are discarded.
  - Data outputs are don't-care while v_o=0. The implementation drives them 0 after reset.
- err_o: sticky; cleared only by reset.

Optional Feature:
- Macro: BSG_MANYCORE_PKT_DECODE_STATS_EN.
- Defined:
  - drop_cnt_o is a 16-bit counter incremented once per dropped packet (mismatch or illegal op).
  - The counter saturates at 16'hFFFF.
- Undefined:
  - The counter register is not built and drop_cnt_o=0 constantly.
  - All other behaviour is identical.

Test Plan:
1. Reset, then my_x=3, my_y=5. Send op=01, addr=20'h00ABC, data=32'hDEADBEEF, mask=4'hF, src=(1,2), dest=(3,5).
   - v_o=1 one cycle later with cfg_o=0, addr_o=20'h00ABC, data_o=32'hDEADBEEF, src_x_o=1, src_y_o=2.
   - yumi_i clears v_o.
2. Hold yumi_i=0 and send 3 legal packets back-to-back.
   - ready_o=0 after the 2nd packet; the 3rd is held by the sender.
   - Pulse yumi_i and ready_o returns to 1 the next cycle.
   - Entries drain in order across the pointer wrap.
3. Send dest=(4,5) with my=(3,5).
   - v_o stays 0 and err_o=0.
   - With STATS_EN, drop_cnt_o=1.
4. Send op=11 with a matching dest.
   - Dropped and err_o=1, held until reset.
   - With STATS_EN, drop_cnt_o increments.
5. With one entry held and yumi_i=1 in the same cycle as a new legal accept:
   - v_o stays 1 and the next head is the new packet.
   - Count remains 1.
6. Assert reset_i with 2 entries queued.
   - Next cycle: v_o=0, ready_o=1, err_o=0, drop_cnt_o=0.
   - A subsequent legal packet appears with 1-cycle latency.
